rtype_sequencer: RTL

- Multi-cycle R-type execution controller; initiator side of the 16x32 register file interface.
- Accepts one 16-bit R-type instruction via valid/ready, drives read indices, captures operands, computes the ALU result and issues a single-cycle write-back strobe.
- Sits between instruction fetch/decode and the register file; one instruction in flight at a time.

---
 rtl/rtype_sequencer_pkg.sv | 30 +++
 rtl/rtype_sequencer_if.sv | 30 +++
 rtl/rtype_sequencer_alu.sv | 49 ++++
 rtl/rtype_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: FSM states, instruction
// field positions and ALU function codes.
package rtype_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam int INSTR_W = 16;
    localparam int RS_LSB  = 12;
    localparam int RT_LSB  = 8;
    localparam int RD_LSB  = 4;
    localparam int FN_LSB  = 0;
    localparam int FN_W    = 4;

    localparam logic [FN_W-1:0] F_ADD = 4'd0;
    localparam logic [FN_W-1:0] F_SUB = 4'd1;
    localparam logic [FN_W-1:0] F_AND = 4'd2;
    localparam logic [FN_W-1:0] F_OR  = 4'd3;
    localparam logic [FN_W-1:0] F_XOR = 4'd4;
    localparam logic [FN_W-1:0] F_NOR = 4'd5;
    localparam logic [FN_W-1:0] F_SLT = 4'd6;
    localparam logic [FN_W-1:0] F_SLL = 4'd7;
    localparam logic [FN_W-1:0] F_SRL = 4'd8;
    localparam logic [FN_W-1:0] F_SRA = 4'd9;

endpackage

// File: rtl/rtype_sequencer_if.sv
// Instruction handshake plus register-file read/write bus.
// master = sequencer side, slave = fetch/decode + register file side.
interface rtype_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    import rtype_sequencer_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [REG_AW-1:0]   rf_rs;
    logic [REG_AW-1:0]   rf_rt;
    logic [DATA_W-1:0]   rf_rd1;
    logic [DATA_W-1:0]   rf_rd2;
    logic [REG_AW-1:0]   rf_rd;
    logic [DATA_W-1:0]   rf_data;
    logic                rf_write;

    modport master (
        input  instr_valid, instr, rf_rd1, rf_rd2,
        output instr_ready, rf_rs, rf_rt, rf_rd, rf_data, rf_write
    );

    modport slave (
        output instr_valid, instr, rf_rd1, rf_rd2,
        input  instr_ready, rf_rs, rf_rt, rf_rd, rf_data, rf_write
    );

endinterface

// File: rtl/rtype_sequencer_alu.sv
// Combinational R-type ALU: A, B, funct -> result, signed overflow, illegal.
module rtype_alu
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FN_W-1:0]   funct,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              illegal
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [SH_W-1:0]   sh;

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = b[SH_W-1:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (funct)
            F_ADD: begin
                result   = sum;
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            F_SUB: begin
                result   = diff;
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            F_AND: result = a & b;
            F_OR:  result = a | b;
            F_XOR: result = a ^ b;
            F_NOR: result = ~(a | b);
            F_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLL: result = a << sh;
            F_SRL: result = a >> sh;
            F_SRA: result = $signed(a) >>> sh;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type controller: accept, read operands, execute, write back.
// One instruction in flight; 4 cycles per instruction.
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    rtype_sequencer_if.master   bus,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic                overflow,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired_count
);
    state_t state, state_nx;

    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [FN_W-1:0]   funct_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf, alu_ill;

    rtype_alu #(.DATA_W(DATA_W)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .funct    (funct_q),
        .result   (alu_res),
        .overflow (alu_ovf),
        .illegal  (alu_ill)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Strobes are decoded from state so an async reset drops them at once.
    always_comb begin
        state_nx        = state;
        bus.instr_ready = 1'b0;
        bus.rf_write    = 1'b0;
        done            = 1'b0;
        case (state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_nx = S_READ;
            end
            S_READ: state_nx = S_EXEC;
            S_EXEC: state_nx = S_WB;
            S_WB: begin
                done         = 1'b1;
                bus.rf_write = !illegal;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            funct_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            result        <= '0;
            overflow      <= 1'b0;
            illegal       <= 1'b0;
            retired_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        rs_q    <= bus.instr[RS_LSB +: REG_AW];
                        rt_q    <= bus.instr[RT_LSB +: REG_AW];
                        rd_q    <= bus.instr[RD_LSB +: REG_AW];
                        funct_q <= bus.instr[FN_LSB +: FN_W];
                    end
                end
                S_READ: begin
                    a_q <= bus.rf_rd1;
                    b_q <= bus.rf_rd2;
                end
                S_EXEC: begin
                    result   <= alu_res;
                    overflow <= alu_ovf;
                    illegal  <= alu_ill;
                end
                S_WB: retired_count <= retired_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.rf_rs   = rs_q;
    assign bus.rf_rt   = rt_q;
    assign bus.rf_rd   = rd_q;
    assign bus.rf_data = result;

endmodule
